// File: rtl/fp_div_sched_pkg.sv
// Shared types and constants for the fp_div round-robin scheduler.
// Also used by the top-level block, which is built with the optional FPDIV_SCHED_TIMEOUT_EN watchdog.
package fpdiv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bit positions inside the {ov,un,inv,div_zero,inexact} flag vector
    localparam int FLAG_OV  = 4;
    localparam int FLAG_UN  = 3;
    localparam int FLAG_INV = 2;
    localparam int FLAG_DZ  = 1;
    localparam int FLAG_NX  = 0;

    localparam logic [31:0] FP_NANQ = 32'h7FC00000;

    // Rounding-mode codes understood by fp_div
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

endpackage

// File: rtl/fp_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr, searched circularly.
// The pointer register itself lives in the parent block.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Shares one fp_div among NREQ requesters: round-robin grant, operand hold, masked done, tagged response.
// Define FPDIV_SCHED_TIMEOUT_EN to add a WAIT watchdog that answers with a quiet NaN.
module fp_div_sched
    import fpdiv_sched_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int W              = 32,
    parameter int IDW            = 2,
    parameter int MIN_WAIT       = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_rm,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic [4:0]        resp_flags,
    output logic              resp_timeout,
    output logic              busy,
    output logic              div_act,
    output logic [W-1:0]      div_in1,
    output logic [W-1:0]      div_in2,
    output logic [2:0]        div_round_m,
    input  logic [W-1:0]      div_out,
    input  logic              div_done,
    input  logic              div_ov,
    input  logic              div_un,
    input  logic              div_inv,
    input  logic              div_div_zero,
    input  logic              div_inexact
);

`ifdef FPDIV_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // The wait counter only needs to reach the watchdog limit when the watchdog exists
    localparam int CNT_MAX = TO_EN ? TIMEOUT_CYCLES - 1 : MIN_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   wait_cnt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            done_ok;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Gated by rst so a requester never sees an accept that reset then throws away
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);
    assign done_ok   = div_done && (wait_cnt >= CW'(MIN_WAIT));

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            wait_cnt     <= '0;
            div_act      <= 1'b0;
            div_in1      <= '0;
            div_in2      <= '0;
            div_round_m  <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_data    <= '0;
            resp_flags   <= '0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        div_in1     <= req_a[grant_idx*W +: W];
                        div_in2     <= req_b[grant_idx*W +: W];
                        div_round_m <= req_rm[grant_idx*3 +: 3];
                        resp_id     <= grant_idx;
                        div_act     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_act  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (done_ok) begin
                        resp_data               <= div_out;
                        resp_flags[FLAG_OV]     <= div_ov;
                        resp_flags[FLAG_UN]     <= div_un;
                        resp_flags[FLAG_INV]    <= div_inv;
                        resp_flags[FLAG_DZ]     <= div_div_zero;
                        resp_flags[FLAG_NX]     <= div_inexact;
                        resp_valid              <= 1'b1;
                        state                   <= RESP;
                    end
`ifdef FPDIV_SCHED_TIMEOUT_EN
                    else if (wait_cnt == CW'(CNT_MAX)) begin
                        resp_data    <= W'(FP_NANQ);
                        resp_flags   <= 5'(1 << FLAG_INV);
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
`endif
                    else if (wait_cnt != CW'(CNT_MAX)) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        resp_timeout <= 1'b0;
                        rr_ptr       <= (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + IDW'(1);
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_sched.sv
// Randomized bench for fp_div_sched with a stand-in divider and a grant/latency reference model.
// Adds a watchdog scenario when FPDIV_SCHED_TIMEOUT_EN is defined.
module tb_fp_div_sched;
    import fpdiv_sched_pkg::*;

    localparam int NREQ = 4, W = 32, IDW = 2, MIN_WAIT = 3, TIMEOUT_CYCLES = 64, BUDGET = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ*3-1:0] req_rm;
    logic              resp_valid, resp_ready, resp_timeout, busy;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data, div_in1, div_in2, div_out;
    logic [4:0]        resp_flags, mk_flags;
    logic [2:0]        div_round_m;
    logic              div_act, div_done;

    always #5 clk = ~clk;

    fp_div_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_flags(resp_flags), .resp_timeout(resp_timeout), .busy(busy),
        .div_act(div_act), .div_in1(div_in1), .div_in2(div_in2), .div_round_m(div_round_m),
        .div_out(div_out), .div_done(div_done),
        .div_ov(mk_flags[4]), .div_un(mk_flags[3]), .div_inv(mk_flags[2]),
        .div_div_zero(mk_flags[1]), .div_inexact(mk_flags[0])
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in divider behaviour: 6.0/2.0 gives the real quotient, anything else a distinctive mix
    function automatic logic [31:0] ref_quot(logic [31:0] a, logic [31:0] b, logic [2:0] rm);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, rm};
    endfunction

    function automatic logic [4:0] ref_flags(logic [31:0] a, logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 5'd0;
        return a[4:0] ^ b[9:5];
    endfunction

    // Scheduler model: pointer plus circular first-set search
    int          ptr_m = 0;
    logic [31:0] a_v [NREQ];
    logic [31:0] b_v [NREQ];
    logic [2:0]  rm_v[NREQ];

    function automatic int model_grant(logic [NREQ-1:0] v, int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
            req_rm[i*3 +: 3] = rm_v[i];
        end
    endtask

    // Divider stand-in: per-op latency, optional stale done with old data, optional never-done
    int          op_lat = 0;
    bit          op_stale = 0, op_nodone = 0;
    int          mk;
    bit          mk_active = 0;
    logic [31:0] mk_a, mk_b;
    logic [2:0]  mk_rm;

    initial begin
        div_done = 1'b0; div_out = '0; mk_flags = '0;
        forever begin
            @(negedge clk);
            if (div_act) begin
                mk_active = 1; mk = 0;
                mk_a = div_in1; mk_b = div_in2; mk_rm = div_round_m;
                if (!op_stale || op_nodone) div_done = 1'b0;
            end else if (mk_active) begin
                if (op_nodone) div_done = 1'b0;
                else if (mk >= op_lat) begin
                    div_out   = ref_quot(mk_a, mk_b, mk_rm);
                    mk_flags  = ref_flags(mk_a, mk_b);
                    div_done  = 1'b1;
                    mk_active = 0;
                end else div_done = op_stale && (mk < MIN_WAIT);
                mk++;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {resp_valid, div_act, resp_timeout, busy}, 0);
        check({tag, "_div_in"}, {div_in1, div_in2}, 0);
        check({tag, "_rm_id"}, {div_round_m, resp_id}, 0);
        check({tag, "_resp"}, {resp_data, resp_flags}, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    // One full transaction from the current negedge (IDLE) to the negedge after the response handshake
    task automatic run_op(input logic [NREQ-1:0] vld, input int lat, input bit stale, input int hold);
        int g, cyc, acts, exp_lat;
        bit got;
        logic [31:0] ea, eb, ed;
        logic [2:0]  erm;
        logic [4:0]  ef;
        bit          et;
        op_lat = lat; op_stale = stale;
        req_valid = vld; pack_ops();
        g = model_grant(vld, ptr_m);
        ea = a_v[g]; eb = b_v[g]; erm = rm_v[g];
        #1;
        check("grant", req_ready, 64'(1) << g);
        @(negedge clk);
        cyc = 1; acts = 0; got = 0;
        a_v[g] = $urandom; b_v[g] = $urandom; rm_v[g] = 3'($urandom_range(0, 4)); pack_ops();
        while (cyc <= BUDGET) begin
            acts += int'(div_act);
            check("ready_while_busy", req_ready, 0);
            check("div_in_hold", {div_in1, div_in2}, {ea, eb});
            check("rm_hold", div_round_m, erm);
            if (resp_valid) begin got = 1; break; end
            @(negedge clk);
            cyc++;
        end
        if (!got) begin
            check("resp_arrives", 0, 1);
            return;
        end
        if (op_nodone) begin
            ed = FP_NANQ; ef = 5'b00100; et = 1; exp_lat = TIMEOUT_CYCLES + 2;
        end else begin
            ed = ref_quot(ea, eb, erm); ef = ref_flags(ea, eb); et = 0;
            exp_lat = ((lat > MIN_WAIT) ? lat : MIN_WAIT) + 3;
        end
        check("latency", cyc, exp_lat);
        check("act_pulses", acts, 1);
        check("resp_id", resp_id, g);
        check("resp_data", resp_data, ed);
        check("resp_flags", resp_flags, ef);
        check("resp_timeout", resp_timeout, et);
        check("busy_resp", busy, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_resp", {resp_id, resp_flags, resp_data}, {2'(g), ef, ed});
            check("hold_no_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_drop", {resp_valid, resp_timeout, busy}, 0);
        ptr_m = (g + 1) % NREQ;
    endtask

    initial begin
        bit seen;
        req_valid = '0; req_a = '0; req_b = '0; req_rm = '0; resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = $urandom; b_v[i] = $urandom; rm_v[i] = 3'($urandom_range(0, 4));
        end
        pack_ops();
        rst = 1'b1; req_valid = '1;
        repeat (3) @(negedge clk);
        check("ready_in_rst", req_ready, 0);
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Directed 6.0 / 2.0 on requester 0
        a_v[0] = 32'h40C00000; b_v[0] = 32'h40000000; rm_v[0] = RM_RNE;
        run_op(4'b0001, 5, 0, 0);

        // All requesters held valid: strict rotation
        for (int k = 0; k < 8; k++) run_op(4'b1111, $urandom_range(0, 6), 0, 0);

        // Response back-pressure, then the next ID wins
        run_op(4'b1111, 2, 0, 10);
        run_op(4'b1111, 1, 0, 0);

        // Stale done with old data during ISSUE and the masked WAIT cycles
        run_op(4'b1111, MIN_WAIT, 1, 0);
        run_op(4'b1001, MIN_WAIT + 2, 1, 1);

        // Reset in the middle of WAIT: no response, pointer back to 0
        run_op(4'b0001, 0, 0, 0);
        op_lat = 6; op_stale = 0;
        req_valid = 4'b0100; pack_ops();
        repeat (3) @(negedge clk);
        check("busy_before_rst", busy, 1);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        ptr_m = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check("no_resp_after_rst", seen, 0);
        run_op(4'b1111, 4, 0, 0);

        // Random traffic
        for (int k = 0; k < 24; k++) begin
            run_op(NREQ'($urandom_range(1, 15)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

`ifdef FPDIV_SCHED_TIMEOUT_EN
        op_nodone = 1;
        run_op(4'b0010, 0, 0, 2);
        op_nodone = 0;
`endif

        req_valid = '0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_sched.md
Name: fp_div_sched

Overview:
Round-robin scheduler that shares one fp_div instance among NREQ requesters. Each requester uses a valid/ready request handshake. The block captures the granted operands and holds them stable on the divider, drives act, and waits for done while masking stale done from earlier operations. It returns the result plus exception flags on a shared response bus tagged with the requester ID. Sits between the wishbone/CSR front-end and the fp_div datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width
IDW, 2, requester ID width, equal to clog2(NREQ)
MIN_WAIT, 3, cycles after act during which div_done is ignored
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the macro)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot accept pulse
req_a  in  NREQ*W  dividends, requester i at [i*W +: W]
req_b  in  NREQ*W  divisors
req_rm  in  NREQ*3  rounding modes
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  IDW  requester owning the response
resp_data  out  W  quotient
resp_flags  out  5  {ov,un,inv,div_zero,inexact}
resp_timeout  out  1  response produced by watchdog
busy  out  1  state != IDLE
div_act  out  1  to fp_div act
div_in1  out  W  to fp_div in1
div_in2  out  W  to fp_div in2
div_round_m  out  3  to fp_div round_m
div_out  in  W  from fp_div out
div_done  in  1  from fp_div done
div_ov, div_un, div_inv, div_div_zero, div_inexact  in  1 each  fp_div flags

Behaviour:
- Reset, taken at the clk edge while rst=1, from any state including mid-operation:
  - state goes to IDLE; rr pointer goes to 0.
  - All outputs go to 0, including the div_in* hold registers.
  - An in-flight operation is discarded and produces no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit at or after the pointer, searching circularly.
  - Same cycle: req_ready[g]=1 (combinational, one cycle). Latch req_a/req_b/req_rm[g] into div_in1/div_in2/div_round_m; latch resp_id=g. Go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: div_act=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - div_act=0; counter increments each cycle, saturating.
  - div_done is ignored while counter < MIN_WAIT.
  - First cycle with counter >= MIN_WAIT and div_done=1: capture div_out into resp_data and the five flags into resp_flags. Go to RESP.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready=1.
  - resp_valid may not drop without resp_ready.
  - On the handshake: pointer = g+1 mod NREQ; go to IDLE.
- div_in1/div_in2/div_round_m stay constant from ISSUE through RESP.
- Minimum request-to-response latency: MIN_WAIT+3 cycles (accept, act, MIN_WAIT wait cycles, capture).
- Throughput: one operation in flight. The next grant can occur in the cycle after the response handshake.
- Fairness: a requester that holds req_valid is granted within NREQ operations.
- req_valid with no grant: no side effect; the requester must hold its operands.
- Simultaneous rst and any handshake: rst wins.

Optional Feature:
- Macro FPDIV_SCHED_TIMEOUT_EN.
- When defined: if WAIT reaches TIMEOUT_CYCLES without a qualified div_done, go to RESP with:
  - resp_data=32'h7FC00000
  - resp_flags=5'b00100 (inv)
  - resp_timeout=1
- resp_timeout clears on the response handshake.
- When undefined: no watchdog; WAIT lasts until div_done; resp_timeout is tied 0 and the counter saturates at MIN_WAIT.

Decomposition:
- Package fpdiv_sched_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - flag bit indices (OV=4, UN=3, INV=2, DZ=1, NX=0)
  - FP_NANQ constant 32'h7FC00000
  - rounding-mode codes shared with fp_div
- Sub-module rr_arbiter: NREQ-wide request vector plus pointer in, one-hot grant and index out; purely combinational; the pointer register stays in fp_div_sched.

Test Plan:
- Single op, rm=RNe, req0 a=32'h40C00000 b=32'h40000000, real fp_div → resp_id=0, resp_data=32'h40400000, flags=0, latency >= MIN_WAIT+3, div_act high exactly 1 cycle.
- req_valid=4'b1111 held for 8 ops → grant order 0,1,2,3,0,1,2,3; each req_ready a single one-hot pulse.
- resp_ready held 0 for 10 cycles in RESP → resp_valid, resp_data, resp_id stable; no new req_ready; grant after handshake goes to the next ID.
- Stale done: force div_done=1 during ISSUE and the first MIN_WAIT cycles of WAIT → ignored; capture occurs only after MIN_WAIT.
- rst=1 asserted in WAIT → next cycle IDLE, all outputs 0, pointer 0; the later div_done produces no response.
- With FPDIV_SCHED_TIMEOUT_EN, div_done tied 0 → response after TIMEOUT_CYCLES with 32'h7FC00000, flags=5'b00100, resp_timeout=1.
